// File: rtl/dla_mov_ddr2gb.sv
// dla_mov_ddr2gb
// Move engine behind the DDR2GB register interface. A go_mov_ddr2gb pulse
// starts one burst using the staged stgr_ddr2gb_* parameters:
//   dir=0 : DDR read burst, each read beat written straight into the GB
//   dir=1 : GB reads through a 2-entry skid FIFO into a DDR write burst
//
// Ports
//   clk, rst                  core clock, asynchronous active-high reset
//   go_mov_ddr2gb             one-cycle start pulse
//   stgr_ddr2gb_*             staged burst parameters (captured in LOAD)
//   ddr_req_*                 DDR request channel (valid/ready, addr, len, wr)
//   ddr_rvalid/rdata/rready   DDR read-data channel
//   ddr_wvalid/wready/wdata/wlast  DDR write-data channel
//   gb_en/we/ab_sel/ramidx/addr/wdata, gb_rdata  GB port (1-cycle read latency)
//   mov_busy, mov_done        status back to the controller
//   mov_err, mov_err_clr      sticky busy-overlap error and its clear
//
// Configuration
//   DLA_MOV_BUSY_ERR_EN : when defined, a go while busy sets the sticky
//   mov_err (mov_err_clr wins over a simultaneous set). When undefined,
//   mov_err is tied to 0 and mov_err_clr is ignored.

module dla_mov_ddr2gb #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go_mov_ddr2gb,
  input  logic [53:0]   stgr_ddr2gb_ddr_addr,
  input  logic          stgr_ddr2gb_ab_sel,
  input  logic [12:0]   stgr_ddr2gb_gb_addr,
  input  logic [3:0]    stgr_ddr2gb_gb_ramidx,
  input  logic          stgr_ddr2gb_dir,
  input  logic [7:0]    stgr_ddr2gb_len,
  output logic          ddr_req_valid,
  input  logic          ddr_req_ready,
  output logic [53:0]   ddr_req_addr,
  output logic [7:0]    ddr_req_len,
  output logic          ddr_req_wr,
  input  logic          ddr_rvalid,
  input  logic [DW-1:0] ddr_rdata,
  output logic          ddr_rready,
  output logic          ddr_wvalid,
  input  logic          ddr_wready,
  output logic [DW-1:0] ddr_wdata,
  output logic          ddr_wlast,
  output logic          gb_en,
  output logic          gb_we,
  output logic          gb_ab_sel,
  output logic [3:0]    gb_ramidx,
  output logic [12:0]   gb_addr,
  output logic [DW-1:0] gb_wdata,
  input  logic [DW-1:0] gb_rdata,
  output logic          mov_busy,
  output logic          mov_done,
  output logic          mov_err,
  input  logic          mov_err_clr
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REQ,
    RD_DATA,
    WR_DATA,
    DONE
  } state_t;

  state_t state, state_nxt;

  // Burst parameters captured in LOAD
  logic [53:0]   ddr_addr_q;
  logic          ab_sel_q;
  logic [3:0]    ramidx_q;
  logic          dir_q;
  logic [7:0]    len_q;

  // cur_addr is the next GB word to access; beat_cnt counts DDR beats done
  logic [12:0]   cur_addr;
  logic [7:0]    beat_cnt;
  logic [8:0]    issue_cnt;
  logic          rd_inflight;

  // 2-entry skid FIFO between GB reads and DDR write data
  logic [DW-1:0] fifo_mem [2];
  logic          fifo_wptr;
  logic          fifo_rptr;
  logic [1:0]    fifo_cnt;

  logic          rd_beat;
  logic          fifo_push;
  logic          fifo_pop;
  logic          gb_issue;
  logic [2:0]    slots_used;

  // Handshake qualifiers and GB read issue. Occupancy is taken after this
  // cycle's pop so a steady wready=1 stream sustains one beat per cycle; the
  // read issued now lands next cycle, when at most one entry is still held.
  always_comb begin
    rd_beat    = (state == RD_DATA) && ddr_rvalid;
    fifo_push  = rd_inflight;
    fifo_pop   = (state == WR_DATA) && (fifo_cnt != 2'd0) && ddr_wready;
    slots_used = {1'b0, fifo_cnt} - {2'b00, fifo_pop} + {2'b00, rd_inflight};
    gb_issue   = (state == WR_DATA) && (slots_used < 3'd2) &&
                 (issue_cnt <= {1'b0, len_q});
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; every output defaults to 0 so the idle
  // and reset views of the port are all zeros
  always_comb begin
    state_nxt     = state;
    ddr_req_valid = 1'b0;
    ddr_req_addr  = '0;
    ddr_req_len   = '0;
    ddr_req_wr    = 1'b0;
    ddr_rready    = 1'b0;
    ddr_wvalid    = 1'b0;
    ddr_wdata     = '0;
    ddr_wlast     = 1'b0;
    gb_en         = 1'b0;
    gb_we         = 1'b0;
    gb_ab_sel     = 1'b0;
    gb_ramidx     = '0;
    gb_addr       = '0;
    gb_wdata      = '0;
    mov_done      = 1'b0;

    case (state)
      IDLE: begin
        if (go_mov_ddr2gb) begin
          state_nxt = LOAD;
        end
      end

      LOAD: begin
        state_nxt = REQ;
      end

      REQ: begin
        ddr_req_valid = 1'b1;
        ddr_req_addr  = ddr_addr_q;
        ddr_req_len   = len_q;
        ddr_req_wr    = dir_q;
        if (ddr_req_ready) begin
          state_nxt = dir_q ? WR_DATA : RD_DATA;
        end
      end

      RD_DATA: begin
        ddr_rready = 1'b1;
        if (ddr_rvalid) begin
          gb_en     = 1'b1;
          gb_we     = 1'b1;
          gb_ab_sel = ab_sel_q;
          gb_ramidx = ramidx_q;
          gb_addr   = cur_addr;
          gb_wdata  = ddr_rdata;
          if (beat_cnt == len_q) begin
            state_nxt = DONE;
          end
        end
      end

      WR_DATA: begin
        if (fifo_cnt != 2'd0) begin
          ddr_wvalid = 1'b1;
          ddr_wdata  = fifo_mem[fifo_rptr];
          ddr_wlast  = (beat_cnt == len_q);
        end
        if (gb_issue) begin
          gb_en     = 1'b1;
          gb_ab_sel = ab_sel_q;
          gb_ramidx = ramidx_q;
          gb_addr   = cur_addr;
        end
        if (fifo_pop && (beat_cnt == len_q)) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        mov_done  = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign mov_busy = (state != IDLE);

  // Burst datapath: parameter capture, address/beat counters and skid FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ddr_addr_q  <= '0;
      ab_sel_q    <= 1'b0;
      ramidx_q    <= '0;
      dir_q       <= 1'b0;
      len_q       <= '0;
      cur_addr    <= '0;
      beat_cnt    <= '0;
      issue_cnt   <= '0;
      rd_inflight <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wptr   <= 1'b0;
      fifo_rptr   <= 1'b0;
      fifo_cnt    <= '0;
    end else begin
      case (state)
        LOAD: begin
          ddr_addr_q  <= stgr_ddr2gb_ddr_addr;
          ab_sel_q    <= stgr_ddr2gb_ab_sel;
          ramidx_q    <= stgr_ddr2gb_gb_ramidx;
          dir_q       <= stgr_ddr2gb_dir;
          len_q       <= stgr_ddr2gb_len;
          cur_addr    <= stgr_ddr2gb_gb_addr;
          beat_cnt    <= '0;
          issue_cnt   <= '0;
          rd_inflight <= 1'b0;
          fifo_wptr   <= 1'b0;
          fifo_rptr   <= 1'b0;
          fifo_cnt    <= '0;
        end

        RD_DATA: begin
          if (rd_beat) begin
            cur_addr <= cur_addr + 13'd1;
            beat_cnt <= beat_cnt + 8'd1;
          end
        end

        WR_DATA: begin
          rd_inflight <= gb_issue;
          if (gb_issue) begin
            cur_addr  <= cur_addr + 13'd1;
            issue_cnt <= issue_cnt + 9'd1;
          end
          if (fifo_push) begin
            fifo_mem[fifo_wptr] <= gb_rdata;
            fifo_wptr           <= ~fifo_wptr;
          end
          if (fifo_pop) begin
            fifo_rptr <= ~fifo_rptr;
            beat_cnt  <= beat_cnt + 8'd1;
          end
          fifo_cnt <= fifo_cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end

        default: begin
        end
      endcase
    end
  end

`ifdef DLA_MOV_BUSY_ERR_EN
  // Sticky overlap error; clear takes priority over a same-cycle set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mov_err <= 1'b0;
    end else if (mov_err_clr) begin
      mov_err <= 1'b0;
    end else if (go_mov_ddr2gb && (state != IDLE)) begin
      mov_err <= 1'b1;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = mov_err_clr;
  assign mov_err        = 1'b0;
`endif

endmodule
